// File: rtl/param_calculator_if.sv
// Bundle of the calculator's front-panel signals.
//   Switchs  [WIDTH+3:0] : [WIDTH-1:0] operand, [WIDTH+3:WIDTH] opcode
//   Enter, Clear         : push-button levels, asynchronous to the clock
//   Display  [WIDTH-1:0] : value shown for the current state
//   Leds     [3:0]       : state indicator
//   Busy                 : calculation in progress
//   Zero/Overflow/Error  : result flags, valid only while showing a result
// master = panel/stimulus side, slave = calculator side.
interface param_calculator_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH+3:0] Switchs;
  logic             Enter;
  logic             Clear;
  logic [WIDTH-1:0] Display;
  logic [3:0]       Leds;
  logic             Busy;
  logic             Zero;
  logic             Overflow;
  logic             Error;

  modport master (
    output Switchs, Enter, Clear,
    input  Display, Leds, Busy, Zero, Overflow, Error
  );

  modport slave (
    input  Switchs, Enter, Clear,
    output Display, Leds, Busy, Zero, Overflow, Error
  );
endinterface

// File: rtl/param_calculator.sv
// Push-button sequenced calculator: enter A, enter B, enter opcode, show result.
// Single-cycle ALU ops plus WIDTH-cycle shift-add multiply and restoring
// divide/modulo. Results can be chained back in as the next A.
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : param_calculator_if.slave (Switchs/Enter/Clear in,
//           Display/Leds/Busy/Zero/Overflow/Error out, all outputs registered)
module param_calculator #(
  parameter int WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  param_calculator_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_WITH_A, S_WITH_B, S_CALC, S_RESULT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
    OP_XOR = 4'd4, OP_NOT = 4'd5, OP_SHL = 4'd6, OP_SHR = 4'd7,
    OP_MUL = 4'd8, OP_DIV = 4'd9, OP_MOD = 4'd10
  } op_e;

  // ---------------------------------------------------------------------
  // Button synchronisers and edge detectors
  // ---------------------------------------------------------------------
  logic       r_ent_s1, r_ent_s2, r_ent_d, r_ent_arm;
  logic       r_clr_s1, r_clr_s2, r_clr_d, r_clr_arm;
  logic [1:0] r_settle;
  logic       w_enter_p, w_clear_p;

  // A button only arms once its synchronised level has been seen low with
  // the synchroniser holding real samples (r_settle[1]); a button already
  // held through reset therefore needs a release before it can pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ent_s1  <= 1'b0;
      r_ent_s2  <= 1'b0;
      r_ent_d   <= 1'b0;
      r_ent_arm <= 1'b0;
      r_clr_s1  <= 1'b0;
      r_clr_s2  <= 1'b0;
      r_clr_d   <= 1'b0;
      r_clr_arm <= 1'b0;
      r_settle  <= '0;
    end else begin
      r_ent_s1  <= bus.Enter;
      r_ent_s2  <= r_ent_s1;
      r_ent_d   <= r_ent_s2;
      r_ent_arm <= r_ent_arm | (r_settle[1] & ~r_ent_s2);
      r_clr_s1  <= bus.Clear;
      r_clr_s2  <= r_clr_s1;
      r_clr_d   <= r_clr_s2;
      r_clr_arm <= r_clr_arm | (r_settle[1] & ~r_clr_s2);
      r_settle  <= {r_settle[0], 1'b1};
    end
  end

  // Pulse is decoded from flops so the FSM acts on the third edge.
  assign w_enter_p = r_ent_s2 & ~r_ent_d & r_ent_arm;
  assign w_clear_p = r_clr_s2 & ~r_clr_d & r_clr_arm;

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_a, r_b, r_r;
  logic [WIDTH-1:0] r_hi, r_lo;     // MUL: product hi/lo; DIV: remainder/quotient
  logic [CW-1:0]    r_cnt;
  logic             r_zero, r_ovf, r_err;
  logic [WIDTH-1:0] r_display;
  logic [3:0]       r_leds;
  logic             r_busy;

  logic [WIDTH-1:0] w_sw_val;
  op_e              w_sw_op;
  assign w_sw_val = bus.Switchs[WIDTH-1:0];
  assign w_sw_op  = op_e'(bus.Switchs[WIDTH+3:WIDTH]);

  // One shift-add multiply step and one restoring divide step.
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
  logic [WIDTH+1:0] w_div_diff;
  logic [WIDTH-1:0] w_div_rem, w_div_quo;

  always_comb begin
    w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_mul_hi   = w_mul_sum[WIDTH:1];
    w_mul_lo   = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    w_div_diff = {1'b0, r_hi, r_lo[WIDTH-1]} - {2'b00, r_b};
    if (!w_div_diff[WIDTH+1]) begin
      w_div_rem = w_div_diff[WIDTH-1:0];
      w_div_quo = {r_lo[WIDTH-2:0], 1'b1};
    end else begin
      w_div_rem = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
      w_div_quo = {r_lo[WIDTH-2:0], 1'b0};
    end
  end

  // Result and flags as they would be captured on leaving CALC this cycle.
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf, w_err, w_iter, w_done;

  always_comb begin
    w_sum = {1'b0, r_a} + {1'b0, r_b};
    w_res = '0;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (r_op)
      OP_ADD: begin w_res = w_sum[WIDTH-1:0]; w_ovf = w_sum[WIDTH]; end
      OP_SUB: begin w_res = r_a - r_b;        w_ovf = (r_a < r_b); end
      OP_AND: w_res = r_a & r_b;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_NOT: w_res = ~r_a;
      OP_SHL: begin w_res = {r_a[WIDTH-2:0], 1'b0}; w_ovf = r_a[WIDTH-1]; end
      OP_SHR: w_res = {1'b0, r_a[WIDTH-1:1]};
      OP_MUL: begin w_res = w_mul_lo; w_ovf = |w_mul_hi; end
      OP_DIV: if (r_b == '0) w_err = 1'b1; else w_res = w_div_quo;
      OP_MOD: if (r_b == '0) w_err = 1'b1; else w_res = w_div_rem;
      default: w_err = 1'b1;
    endcase
    w_iter = (r_op == OP_MUL) || (r_op == OP_DIV) || (r_op == OP_MOD);
    w_done = !w_iter || (r_cnt == CW'(WIDTH - 1));
  end

  logic w_enter_ok, w_abort;
  assign w_enter_ok = w_enter_p & ~w_clear_p;
  assign w_abort    = (w_clear_p && (r_state != S_IDLE)) ||
                      (w_enter_p && (r_state == S_RESULT) && r_err);

  // ---------------------------------------------------------------------
  // Sequencer with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset || w_abort) begin
      r_state   <= S_IDLE;
      r_op      <= OP_ADD;
      r_a       <= '0;
      r_b       <= '0;
      r_r       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_zero    <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
      r_display <= '0;
      r_leds    <= 4'b0001;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_enter_ok) begin
          r_a       <= w_sw_val;
          r_display <= w_sw_val;
          r_leds    <= 4'b0011;
          r_state   <= S_WITH_A;
        end
        S_WITH_A: if (w_enter_ok) begin
          r_b       <= w_sw_val;
          r_display <= w_sw_val;
          r_leds    <= 4'b0111;
          r_state   <= S_WITH_B;
        end
        S_WITH_B: if (w_enter_ok) begin
          r_op    <= w_sw_op;
          r_cnt   <= '0;
          r_hi    <= '0;
          r_lo    <= (w_sw_op == OP_MUL) ? r_b : r_a;
          r_busy  <= 1'b1;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_hi  <= (r_op == OP_MUL) ? w_mul_hi : w_div_rem;
          r_lo  <= (r_op == OP_MUL) ? w_mul_lo : w_div_quo;
          r_cnt <= r_cnt + 1'b1;
          if (w_done) begin
            r_r       <= w_res;
            r_display <= w_res;
            r_ovf     <= w_ovf;
            r_err     <= w_err;
            r_zero    <= (w_res == '0) && !w_err;
            r_busy    <= 1'b0;
            r_leds    <= 4'b1111;
            r_state   <= S_RESULT;
          end
        end
        S_RESULT: if (w_enter_ok) begin
          // Error results are handled by w_abort; this is the chaining path.
          r_a       <= r_r;
          r_b       <= '0;
          r_op      <= OP_ADD;
          r_display <= r_r;
          r_zero    <= 1'b0;
          r_ovf     <= 1'b0;
          r_err     <= 1'b0;
          r_leds    <= 4'b0011;
          r_state   <= S_WITH_A;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.Display  = r_display;
  assign bus.Leds     = r_leds;
  assign bus.Busy     = r_busy;
  assign bus.Zero     = r_zero;
  assign bus.Overflow = r_ovf;
  assign bus.Error    = r_err;

endmodule

// File: tb/tb_param_calculator.sv
// Self-checking bench for param_calculator (WIDTH=8): fixed vector table,
// randomized operations against an arithmetic reference model, and
// hand-written sequences for button timing, chaining, abort and reset.
module tb_param_calculator;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  param_calculator_if #(.WIDTH(8)) u_if ();

  param_calculator #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.slave)
  );

  int n_pass  = 0;
  int n_total = 0;
  int busy_total = 0;

  always @(negedge clock) if (u_if.Busy) busy_total <= busy_total + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] r;
    logic       ovf;
    logic       err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic press_enter(input logic [11:0] sw);
    @(negedge clock);
    u_if.Switchs = sw;
    u_if.Enter = 1'b1;
    repeat (4) @(negedge clock);
    u_if.Enter = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic press_clear();
    @(negedge clock);
    u_if.Clear = 1'b1;
    repeat (4) @(negedge clock);
    u_if.Clear = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic wait_leds(input logic [3:0] leds, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (u_if.Leds == leds) break;
      @(negedge clock);
    end
    check(name, u_if.Leds, leds);
  endtask

  task automatic run_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                          output int busy_cycles);
    int b0;
    press_enter({4'h0, a});
    press_enter({4'h0, b});
    b0 = busy_total;
    press_enter({op, 8'h00});
    wait_leds(4'b1111, 100, "reach_result");
    busy_cycles = busy_total - b0;
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic void model(input int a, input int b, input int op,
                                output int r, output int ovf, output int err);
    int s;
    r = 0; ovf = 0; err = 0;
    case (op)
      0: begin s = a + b; r = s % 256; ovf = (s > 255); end
      1: begin r = (a - b + 256) % 256; ovf = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = (a * 2) % 256; ovf = (a >= 128); end
      7: r = a / 2;
      8: begin s = a * b; r = s % 256; ovf = (s > 255); end
      9: if (b == 0) err = 1; else r = a / b;
      10: if (b == 0) err = 1; else r = a % b;
      default: err = 1;
    endcase
  endfunction

  task automatic check_result(input string tag, input int a, input int b, input int op,
                              input int r, input int ovf, input int err, input int busy);
    int exp_busy;
    exp_busy = (op >= 8 && op <= 10) ? 8 : 1;
    check({tag, "_display"}, u_if.Display, err ? 0 : r);
    check({tag, "_overflow"}, u_if.Overflow, err ? 0 : ovf);
    check({tag, "_error"}, u_if.Error, err);
    check({tag, "_zero"}, u_if.Zero, (r == 0 && err == 0) ? 1 : 0);
    check({tag, "_busy_cycles"}, busy, exp_busy);
    // Error results leave via Enter, others via Clear; both land in IDLE.
    if (err != 0) press_enter(12'h000);
    else press_clear();
    check({tag, "_back_idle"}, u_if.Leds, 4'b0001);
    check({tag, "_idle_display"}, u_if.Display, 0);
  endtask

  initial begin
    int busy, r, ovf, err, a, b, op;

    vecs[0]  = '{8'd200, 8'd100, 4'd0,  8'd44,  1'b1, 1'b0};
    vecs[1]  = '{8'd5,   8'd3,   4'd0,  8'd8,   1'b0, 1'b0};
    vecs[2]  = '{8'd10,  8'd20,  4'd1,  8'd246, 1'b1, 1'b0};
    vecs[3]  = '{8'd5,   8'd5,   4'd1,  8'd0,   1'b0, 1'b0};
    vecs[4]  = '{8'hF0,  8'h3C,  4'd2,  8'h30,  1'b0, 1'b0};
    vecs[5]  = '{8'hF0,  8'h0F,  4'd3,  8'hFF,  1'b0, 1'b0};
    vecs[6]  = '{8'hAA,  8'hFF,  4'd4,  8'h55,  1'b0, 1'b0};
    vecs[7]  = '{8'h0F,  8'h33,  4'd5,  8'hF0,  1'b0, 1'b0};
    vecs[8]  = '{8'h81,  8'h00,  4'd6,  8'h02,  1'b1, 1'b0};
    vecs[9]  = '{8'h81,  8'h00,  4'd7,  8'h40,  1'b0, 1'b0};
    vecs[10] = '{8'd7,   8'd9,   4'd8,  8'd63,  1'b0, 1'b0};
    vecs[11] = '{8'd20,  8'd20,  4'd8,  8'd144, 1'b1, 1'b0};
    vecs[12] = '{8'd100, 8'd7,   4'd9,  8'd14,  1'b0, 1'b0};
    vecs[13] = '{8'd100, 8'd7,   4'd10, 8'd2,   1'b0, 1'b0};
    vecs[14] = '{8'd50,  8'd0,   4'd9,  8'd0,   1'b0, 1'b1};
    vecs[15] = '{8'd50,  8'd0,   4'd10, 8'd0,   1'b0, 1'b1};
    vecs[16] = '{8'd3,   8'd4,   4'd12, 8'd0,   1'b0, 1'b1};

    // Reset with Enter already held high.
    reset = 1'b1;
    u_if.Switchs = '0;
    u_if.Enter = 1'b1;
    u_if.Clear = 1'b0;
    repeat (5) @(negedge clock);
    check("rst_display", u_if.Display, 0);
    check("rst_leds", u_if.Leds, 4'b0001);
    check("rst_busy", u_if.Busy, 0);
    check("rst_flags", {u_if.Zero, u_if.Overflow, u_if.Error}, 0);
    reset = 1'b0;
    repeat (10) @(negedge clock);
    check("held_enter_no_pulse", u_if.Leds, 4'b0001);
    u_if.Enter = 1'b0;
    repeat (4) @(negedge clock);

    // Enter latency: action on the third edge after the first high sample.
    u_if.Switchs = 12'h011;
    u_if.Enter = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    check("latency_edge2_idle", u_if.Leds, 4'b0001);
    @(posedge clock); #1;
    check("latency_edge3_with_a", u_if.Leds, 4'b0011);
    check("latency_display_a", u_if.Display, 8'h11);
    @(negedge clock);
    repeat (3) @(negedge clock);
    u_if.Enter = 1'b0;
    repeat (3) @(negedge clock);
    press_clear();
    check("clear_from_with_a", u_if.Leds, 4'b0001);

    // Table-driven vectors.
    for (int i = 0; i < 17; i++) begin
      run_calc(vecs[i].a, vecs[i].b, vecs[i].op, busy);
      check("vec_leds_result", u_if.Leds, 4'b1111);
      check_result("vec", vecs[i].a, vecs[i].b, vecs[i].op,
                   vecs[i].r, vecs[i].ovf, vecs[i].err, busy);
    end

    // Randomized operations against the model.
    for (int i = 0; i < 30; i++) begin
      a  = $urandom_range(0, 255);
      b  = (i % 6 == 0) ? 0 : $urandom_range(0, 255);
      op = $urandom_range(0, 15);
      model(a, b, op, r, ovf, err);
      run_calc(a[7:0], b[7:0], op[3:0], busy);
      check_result("rand", a, b, op, r, ovf, err, busy);
    end

    // Chaining 5+3=8 into WITH_A, then a 20-cycle Enter gives one advance.
    run_calc(8'd5, 8'd3, 4'd0, busy);
    check("chain_result", u_if.Display, 8);
    press_enter(12'h000);
    check("chain_leds", u_if.Leds, 4'b0011);
    check("chain_display", u_if.Display, 8);
    @(negedge clock);
    u_if.Switchs = 12'h04D;
    u_if.Enter = 1'b1;
    repeat (20) @(negedge clock);
    u_if.Enter = 1'b0;
    repeat (4) @(negedge clock);
    check("long_press_leds", u_if.Leds, 4'b0111);
    check("long_press_display", u_if.Display, 8'h4D);
    // Chained B is replaced; 8 - 0x4D wraps.
    press_enter({4'd1, 8'h00});
    wait_leds(4'b1111, 20, "chain_sub_result");
    check("chain_sub_value", u_if.Display, (8 - 8'h4D + 256) % 256);
    check("chain_sub_overflow", u_if.Overflow, 1);
    press_clear();

    // Clear early in a multiply aborts it.
    press_enter(12'h007);
    press_enter(12'h009);
    @(negedge clock);
    u_if.Switchs = {4'd8, 8'h00};
    u_if.Enter = 1'b1;
    for (int i = 0; i < 20 && !u_if.Busy; i++) @(negedge clock);
    check("mul_busy_seen", u_if.Busy, 1);
    u_if.Enter = 1'b0;
    u_if.Clear = 1'b1;
    repeat (4) @(negedge clock);
    u_if.Clear = 1'b0;
    check("mul_abort_leds", u_if.Leds, 4'b0001);
    check("mul_abort_busy", u_if.Busy, 0);
    check("mul_abort_display", u_if.Display, 0);
    repeat (3) @(negedge clock);

    // Enter and Clear rising together in WITH_B: Clear wins.
    press_enter(12'h021);
    press_enter(12'h022);
    check("both_pre_leds", u_if.Leds, 4'b0111);
    @(negedge clock);
    u_if.Enter = 1'b1;
    u_if.Clear = 1'b1;
    repeat (4) @(negedge clock);
    u_if.Enter = 1'b0;
    u_if.Clear = 1'b0;
    repeat (3) @(negedge clock);
    check("both_leds", u_if.Leds, 4'b0001);
    check("both_display", u_if.Display, 0);

    // Reset in the middle of a divide.
    press_enter(12'h064);
    press_enter(12'h007);
    @(negedge clock);
    u_if.Switchs = {4'd9, 8'h00};
    u_if.Enter = 1'b1;
    for (int i = 0; i < 20 && !u_if.Busy; i++) @(negedge clock);
    check("div_busy_seen", u_if.Busy, 1);
    @(negedge clock);
    u_if.Enter = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    check("div_reset_leds", u_if.Leds, 4'b0001);
    check("div_reset_busy", u_if.Busy, 0);
    check("div_reset_display", u_if.Display, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    press_enter(12'h0AB);
    check("post_reset_with_a", u_if.Display, 8'hAB);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/param_calculator.md
PARAM_CALCULATOR -- requirements
Module: param_calculator

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 4..32.
REQ-002 clock  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 Switchs  input  WIDTH+4  [WIDTH-1:0] operand value; [WIDTH+3:WIDTH] opcode.
REQ-005 Enter  input  1  push-button level, asynchronous to clock; advances the sequence.
REQ-006 Clear  input  1  push-button level, asynchronous to clock; aborts to IDLE.
REQ-007 Display  output  WIDTH  value selected for display, unsigned binary.
REQ-008 Leds  output  4  state indicator.
REQ-009 Busy  output  1  high while a calculation is in progress.
REQ-010 Zero, Overflow, Error  output  1 each  result flags.

Function
REQ-011 Enter and Clear SHALL each pass through a 2-flop synchroniser, then a rising-edge detector producing one-cycle pulses; a held button SHALL produce exactly one pulse.
REQ-012 Action latency SHALL be 3 clock edges from the first edge that samples the button high.
REQ-013 Clear pulse SHALL take priority over an Enter pulse in the same cycle.
REQ-014 States: IDLE, WITH_A, WITH_B, CALC, RESULT.
REQ-015 IDLE + Enter: A <= Switchs[WIDTH-1:0], go WITH_A.
REQ-016 WITH_A + Enter: B <= Switchs[WIDTH-1:0], go WITH_B.
REQ-017 WITH_B + Enter: Op <= Switchs[WIDTH+3:WIDTH], go CALC.
REQ-018 Clear in any non-IDLE state: A, B, Op, R, flags <= 0, go IDLE.
REQ-019 Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A by 1, 7 SHR A by 1 (logical), 8 MUL, 9 DIV, 10 MOD; 11-15 illegal.
REQ-020 Ops 0-7 and illegal opcodes SHALL spend exactly 1 cycle in CALC; ops 8-10 SHALL spend exactly WIDTH cycles in CALC, using a shift-add multiplier or restoring divider.
REQ-021 Enter pulses in CALC SHALL be ignored; Clear in CALC SHALL abort the iteration and go IDLE.
REQ-022 Results: R = low WIDTH bits of the result; arithmetic is unsigned.
REQ-023 Overflow SHALL be set as follows: ADD on carry-out; SUB when A<B (R = wrapped difference); SHL when A[WIDTH-1]=1; MUL when the upper WIDTH product bits are nonzero; all other ops 0.
REQ-024 Error SHALL be set for DIV or MOD with B=0 and for illegal opcodes; in both cases R=0 and Overflow=0.
REQ-025 Zero SHALL be set when R==0 and Error=0.
REQ-026 CALC completion SHALL go to RESULT.
REQ-027 RESULT + Enter with Error=0: A <= R, B <= 0, Op <= 0, go WITH_A (chaining).
REQ-028 RESULT + Enter with Error=1: behave as Clear.
REQ-029 Display by state: IDLE 0; WITH_A A; WITH_B B; CALC B; RESULT R.
REQ-030 Leds by state: IDLE 0001; WITH_A 0011; WITH_B 0111; CALC 0111; RESULT 1111.
REQ-031 Busy=1 only in CALC.
REQ-032 Zero/Overflow/Error SHALL be driven only in RESULT and be 0 in all other states.
REQ-033 All outputs SHALL be registered or decoded from registered state only; no combinational path from Switchs to outputs.

Reset
REQ-034 reset=1 SHALL force IDLE, A=B=Op=R=0, flags 0, iteration counter 0, synchroniser and edge-detector flops 0.
REQ-035 Resulting outputs: Display=0, Leds=0001, Busy=0.
REQ-036 reset SHALL override Enter/Clear and any in-progress calculation in the same cycle.
REQ-037 A button already held high when reset deasserts SHALL NOT generate a pulse until released and pressed again.

Verification (WIDTH=8)
REQ-038 A=200, B=100, op 0 -> RESULT: Display=44, Overflow=1, Zero=0, Leds=1111.
REQ-039 A=7, B=9, op 8 -> Busy high exactly 8 cycles, then Display=63, Overflow=0.
REQ-040 A=50, B=0, op 9 -> Error=1, Display=0; the next Enter returns to IDLE.
REQ-041 5+3=8, then Enter -> WITH_A with Display=8, Leds=0011; Enter held high for 20 cycles -> exactly one state advance.
REQ-042 Clear pulse on the 4th cycle of MUL -> IDLE, Display=0, Busy=0.
REQ-043 Enter and Clear rising in the same cycle while in WITH_B -> IDLE; reset asserted mid-DIV -> IDLE next edge.
